// File: rtl/ircam_frame_tx_if.sv
// Pixel word stream into the frame transmitter; the master drives the data and valid signals,
// and the slave drives ready.
interface ircam_frame_tx_if;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/ircam_frame_tx.sv
// Serialises one pixel frame into 8N1 UART bytes (5A 5A LEN PIX.. [CSUM when IRCAM_TX_CHECKSUM_EN]); first start bit the
// cycle after frame_start; a late pixel holds the line idle with pix_ready high until the word arrives.
module ircam_frame_tx #(
  parameter int          PIXELS       = 768,
  parameter int          CLKS_PER_BIT = 1,
  parameter logic [15:0] CLAMP_MAX    = 16'd9999
) (
  input  logic           clk460k,
  input  logic           rst,
  input  logic           frame_start,
  ircam_frame_tx_if.slave pix,
  output logic           UART_TX,
  output logic           busy,
  output logic           frame_done
);

  localparam int PIX_W = $clog2(PIXELS + 1);
  localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [15:0]      LEN      = 16'(2 * PIXELS);
  localparam logic [PIX_W-1:0] PIX_N    = PIX_W'(PIXELS);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);
  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    IDLE, HDR0, HDR1, LEN0, LEN1, PIX_LO, PIX_HI,
`ifdef IRCAM_TX_CHECKSUM_EN
    CSUM0, CSUM1,
`endif
    DONE
  } state_t;

  state_t           state;
  logic [3:0]       bit_idx;
  logic [CLK_W-1:0] clk_cnt;
  logic [7:0]       sh;
  logic [15:0]      cur;
  logic [15:0]      pbuf;
  logic             buf_full;
  logic             waiting;
  logic [PIX_W-1:0] pix_cnt;
  logic [PIX_W-1:0] fetch_cnt;
`ifdef IRCAM_TX_CHECKSUM_EN
  logic [15:0]      csum;
`endif

  logic        take;
  logic [15:0] clamped;
  logic        bit_end;
  logic        byte_end;
  logic        to_pix;

  assign pix.pix_ready = ((state == LEN1 || state == PIX_HI) && !buf_full && fetch_cnt < PIX_N)
                       || (state == PIX_LO && waiting);
  assign take     = pix.pix_valid && pix.pix_ready;
  assign clamped  = (pix.pix_data > CLAMP_MAX) ? CLAMP_MAX : pix.pix_data;
  assign bit_end  = (clk_cnt == CLK_LAST);
  assign byte_end = !waiting && bit_end && (bit_idx == 4'd9);
  assign to_pix   = byte_end && (state == LEN1 || (state == PIX_HI && pix_cnt != PIX_LAST));

  always_ff @(posedge clk460k) begin
    if (rst) begin
      state      <= IDLE;
      UART_TX    <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bit_idx    <= '0;
      clk_cnt    <= '0;
      sh         <= '0;
      cur        <= '0;
      pbuf       <= '0;
      buf_full   <= 1'b0;
      waiting    <= 1'b0;
      pix_cnt    <= '0;
      fetch_cnt  <= '0;
`ifdef IRCAM_TX_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      frame_done <= 1'b0;

      // A word taken while the line is idle goes straight to the shifter, not the buffer.
      if (take) begin
        fetch_cnt <= fetch_cnt + PIX_W'(1);
`ifdef IRCAM_TX_CHECKSUM_EN
        csum      <= csum + clamped;
`endif
        if (!waiting) begin
          pbuf     <= clamped;
          buf_full <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          UART_TX <= 1'b1;
          if (frame_start) begin
            state     <= HDR0;
            busy      <= 1'b1;
            UART_TX   <= 1'b0;
            sh        <= 8'h5A;
            bit_idx   <= '0;
            clk_cnt   <= '0;
            pix_cnt   <= '0;
            fetch_cnt <= '0;
            buf_full  <= 1'b0;
            waiting   <= 1'b0;
`ifdef IRCAM_TX_CHECKSUM_EN
            csum      <= 16'h5A5A + LEN;
`endif
          end
        end
        DONE: begin
          state   <= IDLE;
          UART_TX <= 1'b1;
        end
        default: begin
          if (waiting) begin
            if (take) begin
              cur     <= clamped;
              sh      <= clamped[7:0];
              waiting <= 1'b0;
              UART_TX <= 1'b0;
              bit_idx <= '0;
              clk_cnt <= '0;
            end
          end else if (!bit_end) begin
            clk_cnt <= clk_cnt + CLK_W'(1);
          end else if (bit_idx != 4'd9) begin
            clk_cnt <= '0;
            bit_idx <= bit_idx + 4'd1;
            UART_TX <= (bit_idx == 4'd8) ? 1'b1 : sh[bit_idx[2:0]];
          end else begin
            clk_cnt <= '0;
            bit_idx <= '0;
            UART_TX <= 1'b0;
            case (state)
              HDR0:   begin state <= HDR1;   sh <= 8'h5A;      end
              HDR1:   begin state <= LEN0;   sh <= LEN[7:0];   end
              LEN0:   begin state <= LEN1;   sh <= LEN[15:8];  end
              PIX_LO: begin state <= PIX_HI; sh <= cur[15:8];  end
              PIX_HI: begin
                if (pix_cnt == PIX_LAST) begin
`ifdef IRCAM_TX_CHECKSUM_EN
                  state <= CSUM0;
                  sh    <= csum[7:0];
`else
                  state      <= DONE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  UART_TX    <= 1'b1;
`endif
                end else begin
                  pix_cnt <= pix_cnt + PIX_W'(1);
                end
              end
`ifdef IRCAM_TX_CHECKSUM_EN
              CSUM0:  begin state <= CSUM1; sh <= csum[15:8]; end
              CSUM1: begin
                state      <= DONE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
                UART_TX    <= 1'b1;
              end
`endif
              default: ;
            endcase
          end

          // Next byte is a pixel low byte: use the buffer, a same-cycle transfer, or wait idle.
          if (to_pix) begin
            state <= PIX_LO;
            if (buf_full) begin
              cur      <= pbuf;
              sh       <= pbuf[7:0];
              buf_full <= 1'b0;
            end else if (take) begin
              cur      <= clamped;
              sh       <= clamped[7:0];
              buf_full <= 1'b0;
            end else begin
              waiting <= 1'b1;
              UART_TX <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ircam_frame_tx.sv
// Scoreboard bench: expected bytes are queued per frame, a UART receiver pops and compares them.
module tb_ircam_frame_tx;
`ifdef IRCAM_TX_CHECKSUM_EN
  localparam int PIX = 2;
  localparam int FRAME_SPAN = 101;
`else
  localparam int PIX = 768;
  localparam int FRAME_SPAN = 15401;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic UART_TX, busy, frame_done;

  ircam_frame_tx_if pif ();

  ircam_frame_tx #(.PIXELS(PIX), .CLKS_PER_BIT(1), .CLAMP_MAX(16'd9999)) dut (
    .clk460k(clk), .rst(rst), .frame_start(frame_start), .pix(pif.slave),
    .UART_TX(UART_TX), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  sb[$];
  logic [15:0] words[PIX];
  logic [15:0] expw[PIX];
  int idx = 0;
  int hold_at = -1;
  int hold_left = 0;
  bit drv_en = 0;
  bit chk_start = 0;
  bit chk_gap = 0;
  bit rx_abort = 0;
  int t_first = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // Pixel source: advances on each transfer, optionally withholding one word.
  initial begin
    logic tk;
    pif.pix_valid = 1'b0;
    pif.pix_data  = '0;
    forever begin
      @(negedge clk);
      if (chk_start) begin chk("late_start_bit", UART_TX, 1'b0); chk_start = 0; end
      if (chk_gap) begin
        chk("gap_line_idle", UART_TX, 1'b1);
        chk("gap_ready_held", pif.pix_ready, 1'b1);
        chk_gap = 0;
      end
      tk = pif.pix_valid && pif.pix_ready;
      @(posedge clk); #1;
      if (tk) begin
        if (idx == hold_at) begin chk_start = 1; hold_at = -1; end
        idx++;
      end
      if (idx == hold_at && hold_left > 0) begin
        pif.pix_valid = 1'b0;
        hold_left--;
        if (hold_left == 0) chk_gap = 1;
      end else begin
        pif.pix_valid = drv_en;
      end
      pif.pix_data = (idx < PIX) ? words[idx] : 16'h0;
    end
  end

  // UART receiver, one sample per bit at the falling edge.
  initial begin
    int rx_cnt;
    logic [7:0] rx_sh;
    logic [7:0] e;
    rx_cnt = 0;
    rx_sh = '0;
    forever begin
      @(negedge clk);
      if (rx_abort) begin
        rx_cnt = 0;
      end else if (rx_cnt == 0) begin
        if (UART_TX === 1'b0) begin
          rx_cnt = 1;
          if (t_first < 0) t_first = cyc;
        end
      end else if (rx_cnt <= 8) begin
        rx_sh[rx_cnt-1] = UART_TX;
        rx_cnt++;
      end else begin
        chk("stop_bit", UART_TX, 1'b1);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_byte: got %02h, required no byte", rx_sh);
        end else begin
          e = sb.pop_front();
          chk("uart_byte", rx_sh, e);
        end
        rx_cnt = 0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic push_frame();
`ifdef IRCAM_TX_CHECKSUM_EN
    logic [7:0] lit [10] = '{8'h5A, 8'h5A, 8'h04, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h61, 8'h5A};
    foreach (lit[i]) sb.push_back(lit[i]);
`else
    sb.push_back(8'h5A); sb.push_back(8'h5A); sb.push_back(8'h00); sb.push_back(8'h06);
    for (int i = 0; i < PIX; i++) begin
      sb.push_back(expw[i][7:0]);
      sb.push_back(expw[i][15:8]);
    end
`endif
  endtask

  task automatic go();
    idx = 0;
    t_first = -1;
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    chk("busy_rise", busy, 1'b1);
    chk("first_start_bit", UART_TX, 1'b0);
  endtask

  task automatic wait_done(input bit timed);
    int n = 0;
    while (frame_done !== 1'b1 && n < 40000) begin @(negedge clk); n++; end
    chk("frame_done_seen", frame_done, 1'b1);
    if (timed) chk("frame_span", cyc - t_first + 1, FRAME_SPAN);
    chk("scoreboard_empty", sb.size(), 0);
    chk("busy_fall", busy, 1'b0);
  endtask

  task automatic done_start_ignored();
    int bad = 0;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    @(negedge clk);
    chk("done_pulse_width", frame_done, 1'b0);
    repeat (15) begin
      if (busy !== 1'b0 || UART_TX !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("done_start_ignored", bad, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_uart", UART_TX, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", pif.pix_ready, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    drv_en = 1;

`ifdef IRCAM_TX_CHECKSUM_EN
    words[0] = 16'h0001;
    words[1] = 16'h0002;
    push_frame();
    go();
    wait_done(1);
    done_start_ignored();
`else
    // Frame A: ramp with clamp cases, busy frame_start and DONE-cycle frame_start ignored.
    for (int i = 0; i < PIX; i++) begin words[i] = 16'(3000 + i); expw[i] = 16'(3000 + i); end
    words[10] = 16'hFFFF; expw[10] = 16'd9999;
    words[11] = 16'd9999; expw[11] = 16'd9999;
    words[12] = 16'd10000; expw[12] = 16'd9999;
    words[13] = 16'd0;     expw[13] = 16'd0;
    push_frame();
    go();
    n = 0;
    while (idx < 50 && n < 5000) begin @(negedge clk); n++; end
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(negedge clk);
    chk("busy_start_ignored", busy, 1'b1);
    wait_done(1);
    done_start_ignored();

    // Frame B: pixel 5 withheld for 50 cycles.
    for (int i = 0; i < PIX; i++) begin words[i] = 16'(3000 + i); expw[i] = 16'(3000 + i); end
    hold_at = 5;
    hold_left = 50;
    push_frame();
    go();
    wait_done(0);

    // Frame C: reset in the middle of pixel 100.
    push_frame();
    go();
    n = 0;
    while (idx <= 101 && n < 5000) begin @(negedge clk); n++; end
    chk("reached_pixel_100", idx > 101, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    rx_abort = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_uart", UART_TX, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", pif.pix_ready, 1'b0);
    @(posedge clk); #1;
    rx_abort = 0;
    repeat (5) @(posedge clk);

    // Frame D: clean frame after the abort.
    push_frame();
    go();
    wait_done(1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
